// File: rtl/uart_transmitter.sv
// UART transmit driver: start bit, DATA_BITS data bits LSB-first, optional even parity, then STOP_BIT stop bits.
// Bit timing comes from a 16x NCO; a one-entry holding buffer allows back-to-back frames.
module uart_transmitter #(
  parameter int          DATA_BITS    = 8,
  parameter int          PARITY_BIT   = 0,
  parameter int          STOP_BIT     = 2,
  parameter int          DEFAULT_BDR  = 115200,
  parameter int          SYS_CLK_DIV2 = 25_000_000,
  parameter logic [16:0] NCO_INC      = 17'((64'd16 * 64'(DEFAULT_BDR) * 64'd65536) / 64'(SYS_CLK_DIV2))
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr,
  input  logic [DATA_BITS-1:0] data,
  output logic                 ready,
  output logic                 txd,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           state_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Handshake: a byte is taken on any clk edge where wr=1 and ready=1.
  // ready is registered and low only while the holding buffer is occupied.

  logic [2:0]           state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] buf_q, buf_d;
  logic                 buf_full_q, buf_full_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [1:0]           stop_cnt_q, stop_cnt_d;
  logic                 par_q, par_d;
  logic [15:0]          acc_q, acc_d;
  logic [3:0]           tick_cnt_q, tick_cnt_d;
  logic                 txd_q, txd_d;

  logic [16:0] nco_sum;
  logic        tick;
  logic        accept;
  logic        bit_end;
  logic        start_entry;
  logic        direct_load;

  assign nco_sum = {1'b0, acc_q} + NCO_INC;
  assign tick    = nco_sum[16];
  assign accept  = wr && !buf_full_q;
  assign bit_end = tick && (tick_cnt_q == 4'd15) && (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    par_d       = par_q;
    acc_d       = nco_sum[15:0];
    tick_cnt_d  = tick_cnt_q;
    done        = 1'b0;
    start_entry = 1'b0;
    direct_load = 1'b0;
    txd_d       = 1'b1;

    if (state_q != S_IDLE && tick) tick_cnt_d = tick_cnt_q + 4'd1;

    case (state_q)
      S_IDLE: begin
        // Phase of the bit clock is realigned only when leaving idle.
        if (accept) begin
          shift_d     = data;
          direct_load = 1'b1;
          start_entry = 1'b1;
          acc_d       = '0;
          tick_cnt_d  = '0;
        end else if (buf_full_q) begin
          shift_d     = buf_q;
          buf_full_d  = 1'b0;
          start_entry = 1'b1;
          acc_d       = '0;
          tick_cnt_d  = '0;
        end
      end
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA: begin
        if (bit_end) begin
          par_d     = par_q ^ shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
            state_d    = (PARITY_BIT != 0) ? S_PARITY : S_STOP;
            stop_cnt_d = '0;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d    = S_STOP;
          stop_cnt_d = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_cnt_q == 2'(STOP_BIT - 1)) begin
            done    = 1'b1;
            state_d = S_IDLE;
            // Chain straight into the next frame so no idle bit appears on the line.
            if (buf_full_q) begin
              shift_d     = buf_q;
              buf_full_d  = 1'b0;
              start_entry = 1'b1;
            end else if (accept) begin
              shift_d     = data;
              direct_load = 1'b1;
              start_entry = 1'b1;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start_entry) begin
      state_d   = S_START;
      bit_cnt_d = '0;
      par_d     = 1'b0;
    end

    if (accept && !direct_load) begin
      buf_d      = data;
      buf_full_d = 1'b1;
    end

    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
      S_PARITY: txd_d = par_d;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      par_q      <= 1'b0;
      acc_q      <= '0;
      tick_cnt_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      acc_q      <= acc_d;
      tick_cnt_q <= tick_cnt_d;
      txd_q      <= txd_d;
    end
  end

  assign txd     = txd_q;
  assign ready   = !buf_full_q;
  assign busy    = (state_q != S_IDLE);
  assign state_o = state_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: an 8N2 one-tick-per-clk instance checked every cycle against a
// frame-sample queue model, and an 8E1 half-rate instance checked against hand-written frames.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_a, wr_b;
  logic [7:0] data_a, data_b;
  logic       ready_a, txd_a, busy_a, done_a;
  logic       ready_b, txd_b, busy_b, done_b;
  logic [2:0] state_a, state_b;

  int n_checks = 0;
  int n_err = 0;
  int total_done = 0;

  // Model state: one queue entry per expected clk cycle of line activity.
  logic       exp_q[$];
  logic       last_q[$];
  logic       m_buf_full = 1'b0;
  logic [7:0] m_buf = 8'h00;

  uart_transmitter #(.DATA_BITS(8), .PARITY_BIT(0), .STOP_BIT(2), .NCO_INC(17'h10000)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr(wr_a), .data(data_a),
    .ready(ready_a), .txd(txd_a), .busy(busy_a), .done(done_a), .state_o(state_a)
  );

  uart_transmitter #(.DATA_BITS(8), .PARITY_BIT(1), .STOP_BIT(1), .NCO_INC(17'h08000)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr(wr_b), .data(data_b),
    .ready(ready_b), .txd(txd_b), .busy(busy_b), .done(done_b), .state_o(state_b)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: wait bound expired t=%0t", name, $time);
  endtask

  // ---------------- model ----------------
  task automatic push_frame(input logic [7:0] b);
    logic [10:0] bits;
    bits = {2'b11, b, 1'b0};
    for (int i = 0; i < 11; i++)
      for (int j = 0; j < 16; j++) begin
        exp_q.push_back(bits[i]);
        last_q.push_back(i == 10 && j == 15);
      end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      last_q.delete();
      m_buf_full <= 1'b0;
    end else begin
      if (exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(last_q.pop_front());
      end
      if (exp_q.size() == 0) begin
        if (m_buf_full) begin
          push_frame(m_buf);
          m_buf_full <= 1'b0;
        end else if (wr_a) begin
          push_frame(data_a);
        end
      end else if (wr_a && !m_buf_full) begin
        m_buf      <= data_a;
        m_buf_full <= 1'b1;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    check("txd",   32'(txd_a),   32'(exp_q.size() > 0 ? exp_q[0] : 1'b1));
    check("busy",  32'(busy_a),  32'(exp_q.size() > 0));
    check("done",  32'(done_a),  32'(exp_q.size() > 0 ? last_q[0] : 1'b0));
    check("ready", 32'(ready_a), 32'(!m_buf_full));
    if (done_a) total_done++;
  end

  // ---------------- drivers ----------------
  task automatic send_a(input logic [7:0] b, input bit wait_rdy);
    int n;
    n = 0;
    @(negedge clk);
    while (wait_rdy && !ready_a && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) timeout_fail("send_ready");
    wr_a   = 1'b1;
    data_a = b;
    @(negedge clk);
    wr_a   = 1'b0;
    data_a = 8'($urandom);
  endtask

  task automatic wait_idle(input int expd, input string name);
    int n;
    int dones;
    n = 0;
    dones = 0;
    do begin
      @(negedge clk);
      n++;
      if (done_a) dones++;
    end while (!(n > 1 && !busy_a && ready_a) && n < 3000);
    if (n >= 3000) timeout_fail(name);
    check(name, 32'(dones), 32'(expd));
  endtask

  // Literal frame check for instance A: vec[i] is line bit i, 16 clk per bit.
  task automatic frame_a(input logic [7:0] b, input logic [10:0] vec);
    @(negedge clk);
    wr_a   = 1'b1;
    data_a = b;
    for (int k = 1; k <= 177; k++) begin
      @(negedge clk);
      if (k == 1) begin
        wr_a   = 1'b0;
        data_a = 8'h00;
      end
      if (k % 16 == 8) check("a_bit", 32'(txd_a), 32'(vec[(k - 1) / 16]));
      if (k == 8) check("a_ready_direct", 32'(ready_a), 32'd1);
      if (k == 175) check("a_done_early", 32'(done_a), 32'd0);
      if (k == 176) check("a_done_176", 32'(done_a), 32'd1);
      if (k == 177) check("a_busy_after", 32'(busy_a), 32'd0);
    end
  endtask

  // Literal frame check for instance B: 32 clk per bit, 11 bits including parity.
  task automatic frame_b(input logic [7:0] b, input logic [10:0] vec);
    @(negedge clk);
    wr_b   = 1'b1;
    data_b = b;
    for (int k = 1; k <= 353; k++) begin
      @(negedge clk);
      if (k == 1) begin
        wr_b   = 1'b0;
        data_b = 8'hFF;
      end
      if (k % 32 == 16) check("b_bit", 32'(txd_b), 32'(vec[(k - 1) / 32]));
      if (k == 351) check("b_done_early", 32'(done_b), 32'd0);
      if (k == 352) check("b_done_352", 32'(done_b), 32'd1);
      if (k == 353) check("b_busy_after", 32'(busy_b), 32'd0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    wr_a = 1'b0; data_a = 8'h00;
    wr_b = 1'b0; data_b = 8'h00;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd",   32'(txd_a),   32'd1);
    check("rst_ready", 32'(ready_a), 32'd1);
    check("rst_busy",  32'(busy_a),  32'd0);
    check("rst_done",  32'(done_a),  32'd0);
    check("rst_txd_b", 32'(txd_b),   32'd1);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 8N2 frame of A5: 0, 1,0,1,0,0,1,0,1, 1,1
    frame_a(8'hA5, 11'b111_0100_1010);
    repeat (5) @(negedge clk);

    // Second byte queued mid-frame, sent back-to-back
    send_a(8'h55, 1'b1);
    repeat (40) @(negedge clk);
    send_a(8'h0F, 1'b1);
    check("t3_ready_low", 32'(ready_a), 32'd0);
    wait_idle(2, "t3_dones");

    // Third write while buffer full is dropped
    send_a(8'h11, 1'b1);
    repeat (20) @(negedge clk);
    send_a(8'h22, 1'b1);
    repeat (20) @(negedge clk);
    send_a(8'h33, 1'b0);
    check("t4_ready_still_low", 32'(ready_a), 32'd0);
    wait_idle(2, "t4_dones");

    // Reset during data bit 3 of C3 (bit3 = 0) with 3C queued
    send_a(8'hC3, 1'b1);
    send_a(8'h3C, 1'b1);
    repeat (68) @(negedge clk);
    check("t5_bit3_before", 32'(txd_a), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_txd",   32'(txd_a),   32'd1);
    check("t5_rst_ready", 32'(ready_a), 32'd1);
    check("t5_rst_busy",  32'(busy_a),  32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("t5_queued_discarded", 32'(txd_a), 32'd1);
    send_a(8'h96, 1'b1);
    wait_idle(1, "t5_clean_frame");

    // Write on the final-stop edge with empty buffer: chained with no gap
    send_a(8'h5A, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_a && n < 400);
    if (n >= 400) timeout_fail("t7_done_wait");
    wr_a   = 1'b1;
    data_a = 8'hA6;
    @(negedge clk);
    wr_a = 1'b0;
    check("t7_start_no_gap", 32'(txd_a),   32'd0);
    check("t7_busy",         32'(busy_a),  32'd1);
    check("t7_ready",        32'(ready_a), 32'd1);
    wait_idle(1, "t7_dones");

    // Random bytes paced by ready
    for (int i = 0; i < 24; i++) send_a(8'($urandom_range(0, 255)), 1'b1);
    wait_idle(2, "rand_tail_dones");

    // 8E1 at half rate: 07 -> parity 1, 03 -> parity 0
    frame_b(8'h07, 11'b110_0000_1110);
    repeat (4) @(negedge clk);
    frame_b(8'h03, 11'b100_0000_0110);

    check("total_done_pulses", 32'(total_done), 32'd32);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
